keypad_entry_ctrl: RTL and testbench

Sequencer placed in front of the keypad_lock datapath.
- Accepts single-cycle keypad digit strobes and forwards each digit with its 1..4 position index.
- Waits for the lock's verdict, then holds the door open for a fixed window.
- Counts consecutive failed attempts and imposes a timed lockout after too many.
- Owns all timing and attempt policy; keypad_lock only compares digits.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/kp_timer.sv | 39 +++
 rtl/keypad_entry_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : state encoding and shared widths for keypad_entry_ctrl
// Rev 1.0
// ============================================================================
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_EVAL    = 3'd2,
    ST_OPEN    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  localparam int DIGIT_W = 4;
  localparam int COUNT_W = 3;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kp_timer.sv
`default_nettype none
// ============================================================================
// kp_timer : loadable down-counter that stops at zero and flags expiry
// Rev 1.0
// ============================================================================
module kp_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// keypad_entry_ctrl : digit sequencing, verdict wait, open window and lockout
// Optional inter-digit timeout: define KEYPAD_DIGIT_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int CODE_LEN       = 4,
  parameter int OPEN_CYCLES    = 1000,
  parameter int EVAL_TMO       = 16,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int DIGIT_TMO      = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_clear,
  input  logic               lock_unlocked,
  input  logic               lock_locked,
  output logic [DIGIT_W-1:0] lock_number,
  output logic [COUNT_W-1:0] lock_count,
  output logic               lock_clear,
  output logic               key_ready,
  output logic               door_open,
  output logic               lockout,
  output logic               attempt_fail,
  output logic [3:0]         fail_count,
  output logic [2:0]         state_out
);

  localparam int MAX_CYC = max2(max2(OPEN_CYCLES, EVAL_TMO), max2(LOCKOUT_CYCLES, DIGIT_TMO));
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] OPEN_LD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] EVAL_LD = TMR_W'(EVAL_TMO - 1);
  localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef KEYPAD_DIGIT_TIMEOUT_EN
  localparam logic [TMR_W-1:0] DIGIT_LD = TMR_W'(DIGIT_TMO - 1);
`endif

  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] lock_number_q, lock_number_d;
  logic [COUNT_W-1:0] lock_count_q, lock_count_d;
  logic               lock_clear_q, lock_clear_d;
  logic [3:0]         fail_count_q, fail_count_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_expired;
  logic               digit_ok;
  logic [3:0]         fail_next;

  kp_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  assign digit_ok  = key_valid && (key_digit <= MAX_DIGIT);
  assign fail_next = (fail_count_q == 4'hF) ? 4'hF : fail_count_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    lock_number_d = lock_number_q;
    lock_count_d  = lock_count_q;
    lock_clear_d  = 1'b0;
    fail_count_d  = fail_count_q;
    tmr_load      = 1'b0;
    tmr_value     = '0;

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // A clear strobe always swallows a coincident digit, even in IDLE.
        if (key_clear) begin
          if (state_q == ST_COLLECT) begin
            lock_clear_d = 1'b1;
            lock_count_d = '0;
            state_d      = ST_IDLE;
          end
        end else if (digit_ok) begin
          lock_number_d = key_digit;
          lock_count_d  = lock_count_q + 3'd1;
          if (lock_count_q == COUNT_W'(CODE_LEN - 1)) begin
            state_d   = ST_EVAL;
            tmr_load  = 1'b1;
            tmr_value = EVAL_LD;
          end else begin
            state_d = ST_COLLECT;
`ifdef KEYPAD_DIGIT_TIMEOUT_EN
            tmr_load  = 1'b1;
            tmr_value = DIGIT_LD;
`endif
          end
        end
`ifdef KEYPAD_DIGIT_TIMEOUT_EN
        else if ((state_q == ST_COLLECT) && tmr_expired) begin
          state_d      = ST_FAIL;
          fail_count_d = fail_next;
          lock_clear_d = 1'b1;
          lock_count_d = '0;
        end
`endif
      end

      ST_EVAL: begin
        if (lock_unlocked) begin
          state_d      = ST_OPEN;
          fail_count_d = '0;
          tmr_load     = 1'b1;
          tmr_value    = OPEN_LD;
        end else if (lock_locked || tmr_expired) begin
          state_d      = ST_FAIL;
          fail_count_d = fail_next;
          lock_clear_d = 1'b1;
          lock_count_d = '0;
        end
      end

      ST_OPEN: begin
        if (tmr_expired) begin
          state_d      = ST_IDLE;
          lock_clear_d = 1'b1;
          lock_count_d = '0;
        end
      end

      ST_FAIL: begin
        if (fail_count_q >= 4'(MAX_FAILS)) begin
          state_d   = ST_LOCKOUT;
          tmr_load  = 1'b1;
          tmr_value = LOCK_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_expired) begin
          state_d      = ST_IDLE;
          fail_count_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      lock_number_q <= '0;
      lock_count_q  <= '0;
      lock_clear_q  <= 1'b0;
      fail_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      lock_number_q <= lock_number_d;
      lock_count_q  <= lock_count_d;
      lock_clear_q  <= lock_clear_d;
      fail_count_q  <= fail_count_d;
    end
  end

  assign lock_number  = lock_number_q;
  assign lock_count   = lock_count_q;
  assign lock_clear   = lock_clear_q;
  assign fail_count   = fail_count_q;
  assign state_out    = state_q;
  assign key_ready    = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign door_open    = (state_q == ST_OPEN);
  assign lockout      = (state_q == ST_LOCKOUT);
  assign attempt_fail = (state_q == ST_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keypad_entry_ctrl : directed scenarios plus random traffic vs a phase model
// Rev 1.0
// ============================================================================
module tb_keypad_entry_ctrl;

  localparam int CODE_LEN  = 4;
  localparam int OPEN_C    = 8;
  localparam int EVAL_C    = 4;
  localparam int MAXF      = 3;
  localparam int LOCK_C    = 20;
  localparam int DIGIT_C   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_clear = 1'b0;
  logic       lock_unlocked = 1'b0;
  logic       lock_locked = 1'b0;

  logic [3:0] lock_number;
  logic [2:0] lock_count;
  logic       lock_clear, key_ready, door_open, lockout, attempt_fail;
  logic [3:0] fail_count;
  logic [2:0] state_out;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  keypad_entry_ctrl #(
    .CODE_LEN(CODE_LEN), .OPEN_CYCLES(OPEN_C), .EVAL_TMO(EVAL_C),
    .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK_C), .DIGIT_TMO(DIGIT_C)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .lock_unlocked(lock_unlocked), .lock_locked(lock_locked),
    .lock_number(lock_number), .lock_count(lock_count), .lock_clear(lock_clear),
    .key_ready(key_ready), .door_open(door_open), .lockout(lockout),
    .attempt_fail(attempt_fail), .fail_count(fail_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Phase model: counts elapsed cycles upward against each window length.
  int m_ph, m_ndig, m_last, m_el, m_fails;
  bit m_clr;

  always @(posedge clk or negedge rst) begin
    int ph, nd, last, el, fails;
    bit clr, do_fail;
    if (!rst) begin
      m_ph <= 0; m_ndig <= 0; m_last <= 0; m_el <= 0; m_fails <= 0; m_clr <= 1'b0;
    end else begin
      ph = m_ph; nd = m_ndig; last = m_last; el = m_el; fails = m_fails;
      clr = 1'b0; do_fail = 1'b0;
      case (ph)
        0, 1: begin
          if (key_clear) begin
            if (ph == 1) begin clr = 1'b1; nd = 0; ph = 0; end
          end else if (key_valid && key_digit < 10) begin
            last = key_digit; nd = nd + 1; el = 0;
            ph = (nd == CODE_LEN) ? 2 : 1;
          end else if (ph == 1) begin
`ifdef KEYPAD_DIGIT_TIMEOUT_EN
            if (el + 1 >= DIGIT_C) do_fail = 1'b1; else el = el + 1;
`endif
          end
        end
        2: begin
          if (lock_unlocked) begin ph = 3; fails = 0; el = 0; end
          else if (lock_locked || (el + 1 >= EVAL_C)) do_fail = 1'b1;
          else el = el + 1;
        end
        3: begin
          if (el + 1 >= OPEN_C) begin ph = 0; clr = 1'b1; nd = 0; end
          else el = el + 1;
        end
        4: begin
          if (fails >= MAXF) begin ph = 5; el = 0; end else ph = 0;
        end
        5: begin
          if (el + 1 >= LOCK_C) begin ph = 0; fails = 0; end
          else el = el + 1;
        end
        default: ph = 0;
      endcase
      if (do_fail) begin
        ph = 4; fails = (fails < 15) ? fails + 1 : 15; clr = 1'b1; nd = 0;
      end
      m_ph <= ph; m_ndig <= nd; m_last <= last; m_el <= el; m_fails <= fails; m_clr <= clr;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",        int'(state_out),    m_ph);
      chk("lock_count",   int'(lock_count),   m_ndig);
      chk("lock_number",  int'(lock_number),  m_last);
      chk("lock_clear",   int'(lock_clear),   int'(m_clr));
      chk("fail_count",   int'(fail_count),   m_fails);
      chk("key_ready",    int'(key_ready),    (m_ph <= 1) ? 1 : 0);
      chk("door_open",    int'(door_open),    (m_ph == 3) ? 1 : 0);
      chk("lockout",      int'(lockout),      (m_ph == 5) ? 1 : 0);
      chk("attempt_fail", int'(attempt_fail), (m_ph == 4) ? 1 : 0);
    end
  end

  task automatic tick(input logic kv, input logic [3:0] kd, input logic kc,
                      input logic lu, input logic ll);
    key_valid = kv; key_digit = kd; key_clear = kc;
    lock_unlocked = lu; lock_locked = ll;
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_digit = 4'd0; key_clear = 1'b0;
    lock_unlocked = 1'b0; lock_locked = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    bit kr_seen;
    logic [3:0] code [4];
    code[0] = 4'd1; code[1] = 4'd3; code[2] = 4'd3; code[3] = 4'd7;

    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_key_ready", int'(key_ready), 1);
    chk("rst_state", int'(state_out), 0);
    chk("rst_count", int'(lock_count), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Correct code and the open window
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, code[i], 1'b0, 1'b0, 1'b0);
      chk("t1_count", int'(lock_count), i + 1);
      chk("t1_number", int'(lock_number), int'(code[i]));
    end
    chk("t1_eval", int'(state_out), 2);
    chk("t1_ready", int'(key_ready), 0);
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (door_open && n < 40) begin n++; idle(); end
    chk("t1_open_len", n, 8);
    chk("t1_clear", int'(lock_clear), 1);
    chk("t1_idle", int'(state_out), 0);
    chk("t1_count0", int'(lock_count), 0);

    // Three wrong codes, then lockout
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      chk("t2_fail", int'(attempt_fail), 1);
      chk("t2_fcnt", int'(fail_count), k + 1);
      idle();
      chk("t2_next", int'(state_out), (k == 2) ? 5 : 0);
    end
    n = 1;
    tick(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    chk("t2_lk_count", int'(lock_count), 0);
    kr_seen = 1'b0;
    while (lockout && n < 60) begin
      if (key_ready) kr_seen = 1'b1;
      n++; idle();
    end
    chk("t2_lock_len", n, 20);
    chk("t2_lock_ready", int'(kr_seen), 0);
    chk("t2_fcnt0", int'(fail_count), 0);

    // Abort mid-entry, then clear with a coincident digit
    tick(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("t3_clear", int'(lock_clear), 1);
    chk("t3_count", int'(lock_count), 0);
    chk("t3_state", int'(state_out), 0);
    tick(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("t3_drop", int'(lock_count), 0);

    // Invalid digit, then verdict timeout
    tick(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    chk("t4_bad_digit", int'(lock_count), 0);
    for (int i = 1; i <= 4; i++) tick(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    n = 0;
    while (state_out == 3'd2 && n < 20) begin n++; idle(); end
    chk("t4_eval_len", n, 4);
    chk("t4_fail", int'(attempt_fail), 1);
    chk("t4_fcnt", int'(fail_count), 1);
    idle();

    // Reset during the open window
    for (int i = 0; i < 4; i++) tick(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(); idle();
    chk("t5_open", int'(door_open), 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_door_async", int'(door_open), 0);
    chk("t5_state", int'(state_out), 0);
    chk("t5_ready", int'(key_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("t5_ready_rel", int'(key_ready), 1);

`ifdef KEYPAD_DIGIT_TIMEOUT_EN
    tick(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    repeat (9) idle();
    chk("t6_pre", int'(attempt_fail), 0);
    idle();
    chk("t6_fail", int'(attempt_fail), 1);
    chk("t6_fcnt", int'(fail_count), 1);
`endif

    repeat (4000) begin
      tick(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
